// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arithmetic path: add/sub mode values and the
// serial add/sub controller state.
package alu_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_slice.sv
// One-bit add/subtract cell. The sum/difference bit is a^b^c in both modes;
// the carry/borrow path uses a conditionally inverted copy of a.
module addsub_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_mode,
    output logic o_s,
    output logic o_c
);
    logic w_na, w_nm, w_t0, w_t1, w_am;
    logic w_x, w_g, w_p, w_pc;

    // w_am = a ^ mode: borrow generate is ~a&b, borrow propagate is ~(a^b).
    inv1 u_inv_a    (.i_a(i_a),  .o_y(w_na));
    inv1 u_inv_mode (.i_a(i_mode), .o_y(w_nm));
    and2 u_and_t0   (.i_a(i_a),  .i_b(w_nm),   .o_y(w_t0));
    and2 u_and_t1   (.i_a(w_na), .i_b(i_mode), .o_y(w_t1));
    or2  u_or_am    (.i_a(w_t0), .i_b(w_t1),   .o_y(w_am));

    xor2 u_xor_ab   (.i_a(i_a),  .i_b(i_b),    .o_y(w_x));
    xor2 u_xor_s    (.i_a(w_x),  .i_b(i_c),    .o_y(o_s));

    and2 u_and_g    (.i_a(w_am), .i_b(i_b),    .o_y(w_g));
    xor2 u_xor_p    (.i_a(w_am), .i_b(i_b),    .o_y(w_p));
    and2 u_and_pc   (.i_a(i_c),  .i_b(w_p),    .o_y(w_pc));
    or2  u_or_c     (.i_a(w_g),  .i_b(w_pc),   .o_y(o_c));
endmodule

// File: rtl/alu_gates.sv
// Basic single-bit gate primitives used to build the arithmetic slices.
module xor2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module and2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module or2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a | i_b;
endmodule

module inv1 (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: WIDTH-bit operands are processed DIGIT bits
// per clock, LSB digit first, with the carry/borrow held between digits.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       o_dbg_state
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
        $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and
    // result/flags are held constant for as long as out_valid is high.

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    int               w_base;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_sum;
    logic [DIGIT:0]   w_c;
    logic [WIDTH-1:0] w_next_result;
    logic             w_last;
    logic             w_sign_diff;
    logic             w_res_flip;
    logic             w_ovf;

    always_comb begin
        w_base  = int'(r_cnt) * DIGIT;
        w_a_dig = r_a[w_base +: DIGIT];
        w_b_dig = r_b[w_base +: DIGIT];
    end

    assign w_c[0] = r_carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        addsub_slice u_slice (
            .i_a   (w_a_dig[i]),
            .i_b   (w_b_dig[i]),
            .i_c   (w_c[i]),
            .i_mode(r_mode),
            .o_s   (w_sum[i]),
            .o_c   (w_c[i+1])
        );
    end

    // Full-width view of the result including the digit being computed now,
    // so the flags can be registered together with the final digit.
    always_comb begin
        w_next_result = r_result;
        w_next_result[w_base +: DIGIT] = w_sum;
    end

    assign w_last      = (r_cnt == LAST_CNT);
    assign w_sign_diff = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    assign w_res_flip  = w_next_result[WIDTH-1] ^ r_a[WIDTH-1];
    assign w_ovf       = ((r_mode == MODE_ADD) ? ~w_sign_diff : w_sign_diff) & w_res_flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= MODE_ADD;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_result <= w_next_result;
                    r_carry  <= w_c[DIGIT];
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_c[DIGIT];
                        r_ovf  <= w_ovf;
                        r_zero <= (w_next_result == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign cout        = r_cout;
    assign overflow    = r_ovf;
    assign zero        = r_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (DIGIT = 1, 4, 8) share one
// stimulus stream and are checked against a table and an arithmetic model.
module tb_serial_addsub;
    import alu_pkg::*;

    localparam int W = 8;
    localparam int EW = W + 3;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         cin;

    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   co;
    logic [2:0]   of;
    logic [2:0]   zr;
    logic [W-1:0] res [3];
    logic [1:0]   st  [3];

    int n_checks = 0;
    int n_errors = 0;
    int lat [3];
    int exp_lat [3] = '{9, 3, 2};
    logic [EW-1:0] exp_q [$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .mode(mode), .cin(cin),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
        .cout(co[0]), .overflow(of[0]), .zero(zr[0]), .o_dbg_state(st[0])
    );
    serial_addsub #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .mode(mode), .cin(cin),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
        .cout(co[1]), .overflow(of[1]), .zero(zr[1]), .o_dbg_state(st[1])
    );
    serial_addsub #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .mode(mode), .cin(cin),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
        .cout(co[2]), .overflow(of[2]), .zero(zr[2]), .o_dbg_state(st[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [7:0] x, input logic [7:0] y,
                                            input logic m, input logic c);
        int ux, uy, sx, sy, u, s;
        logic [7:0] r;
        logic rc, rv;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m == 1'b0) begin
            u = ux + uy + int'(c);
            s = sx + sy + int'(c);
            rc = (u > 255);
        end else begin
            u = ux - uy - int'(c);
            s = sx - sy - int'(c);
            rc = (u < 0);
        end
        r  = u[7:0];
        rv = (s > 127) || (s < -128);
        return {r, rc, rv, (r == 8'h00)};
    endfunction

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [EW-1:0] exp);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d result", name, i), 32'(res[i]), 32'(exp[EW-1:3]));
            chk($sformatf("%s d%0d cout", name, i), 32'(co[i]), 32'(exp[2]));
            chk($sformatf("%s d%0d overflow", name, i), 32'(of[i]), 32'(exp[1]));
            chk($sformatf("%s d%0d zero", name, i), 32'(zr[i]), 32'(exp[0]));
        end
    endtask

    task automatic check_idle(input string name);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d in_ready", name, i), 32'(ir[i]), 32'd1);
            chk($sformatf("%s d%0d out_valid", name, i), 32'(ov[i]), 32'd0);
            chk($sformatf("%s d%0d result", name, i), 32'(res[i]), 32'd0);
            chk($sformatf("%s d%0d flags", name, i), {29'd0, co[i], of[i], zr[i]}, 32'd0);
            chk($sformatf("%s d%0d state", name, i), 32'(st[i]), 32'(IDLE));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb,
                            input logic tm, input logic tc, input string name);
        @(negedge clk);
        a = ta; b = tb; mode = tm; cin = tc;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // operand changes after the accept edge must not matter
        a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); cin = 1'($urandom);
        chk($sformatf("%s in_ready after accept", name), 32'(ir), 32'd0);
    endtask

    task automatic wait_all_done(input string name);
        int edges;
        logic [2:0] seen;
        edges = 1;
        seen = 3'b000;
        for (int i = 0; i < 3; i++) lat[i] = -1;
        while (seen != 3'b111 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    lat[i] = edges;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d latency", name, i), 32'(lat[i]), 32'(exp_lat[i]));
        end
    endtask

    task automatic release_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("%s out_valid after handshake", name), 32'(ov), 32'd0);
        chk($sformatf("%s in_ready after handshake", name), 32'(ir), 32'h7);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tm, input logic tc, input string name);
        logic [EW-1:0] exp;
        start_op(ta, tb, tm, tc, name);
        wait_all_done(name);
        exp = exp_q.pop_front();
        check_outputs(name, exp);
        release_out(name);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [8];

    initial begin
        logic [EW-1:0] exp;
        logic [7:0] ra, rb;
        logic rm, rc;

        vecs[0] = '{8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h5A, 8'h5A, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            exp_q.push_back({vecs[k].res, vecs[k].cout, vecs[k].ovf, vecs[k].zero});
            do_op(vecs[k].a, vecs[k].b, vecs[k].mode, vecs[k].cin, $sformatf("vec%0d", k));
        end

        // backpressure: hold DONE, ignore new requests, accept one cycle after release
        exp = model(8'h05, 8'h03, 1'b1, 1'b0);
        start_op(8'h05, 8'h03, 1'b1, 1'b0, "bp");
        wait_all_done("bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); cin = 1'($urandom);
            @(posedge clk);
            #1;
            check_outputs($sformatf("bp hold%0d", c), exp);
            chk($sformatf("bp hold%0d in_ready", c), 32'(ir), 32'd0);
            chk($sformatf("bp hold%0d out_valid", c), 32'(ov), 32'h7);
        end
        @(negedge clk);
        a = 8'h7F; b = 8'h01; mode = 1'b0; cin = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release out_valid", 32'(ov), 32'd0);
        chk("bp release in_ready", 32'(ir), 32'h7);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp next accept in_ready", 32'(ir), 32'd0);
        wait_all_done("bp next");
        check_outputs("bp next", model(8'h7F, 8'h01, 1'b0, 1'b0));
        release_out("bp next");

        // reset in the middle of RUN (DIGIT=1) while the wider instances are in DONE
        start_op(8'h12, 8'h34, 1'b0, 1'b0, "rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model(8'hC3, 8'h3C, 1'b1, 1'b1));
        do_op(8'hC3, 8'h3C, 1'b1, 1'b1, "after_rst");

        // randomized operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, rm, rc));
            do_op(ra, rb, rm, rc, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, parametrised add/subtract unit for the ALU arithmetic path.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, through a chain of 1-bit add/sub slices.
- Carry/borrow is held in a register between digits.
- Valid/ready handshake on input and output; reports carry/borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. If it does not, the design is a compile-time error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  unit can accept an operation.
- a  in  WIDTH  minuend or augend, unsigned or two's complement.
- b  in  WIDTH  subtrahend or addend.
- mode  in  1  0 = add (a+b+cin), 1 = subtract (a-b-cin).
- cin  in  1  carry-in for add, borrow-in for subtract.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  carry-out for add, borrow-out for subtract.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset:
  - State goes to IDLE; digit counter and carry register go to 0.
  - in_ready=1; out_valid=0; result, cout, overflow and zero all 0.
- Reset has priority over every other event. Asserting rst mid-RUN or in DONE aborts the operation, discards the partial result, and returns to IDLE on the next edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a, b, mode; load the carry register from cin; clear the counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, digit k (bits k*DIGIT+DIGIT-1..k*DIGIT) is computed from the latched operands and the carry register. It is written into result, and the carry register is updated.
  - The counter increments. After the last digit (k = WIDTH/DIGIT-1), go to DONE.
  - RUN lasts exactly WIDTH/DIGIT cycles.
- DONE:
  - out_valid=1; result and flags are stable and held.
  - On out_ready: go to IDLE; out_valid drops on the next edge.
  - Holding out_ready low holds DONE indefinitely, with outputs unchanged.
- Latency: out_valid rises WIDTH/DIGIT+1 edges after the accept edge.
- No overlap between operations: the next accept happens at the earliest one cycle after the output handshake. Changes on a, b, mode and cin outside the accept cycle are ignored.
- Slice function, per bit:
  - add: s = a^b^c; c' = (a&b)|(c&(a^b)).
  - sub: d = a^b^c; c' = (~a&b)|(c&~(a^b)).
- Flags are computed at the final digit and registered with it:
  - cout = final carry register value.
  - add overflow = (a[W-1]==b[W-1]) & (result[W-1]!=a[W-1]).
  - sub overflow = (a[W-1]!=b[W-1]) & (result[W-1]!=a[W-1]).
  - zero = (result==0) over the full WIDTH.
- Boundary cases:
  - cin=1 with a=b in subtract gives all-ones with cout=1.
  - 0xFF+0x01 wraps to 0 with cout=1.
- Counter width is $clog2(WIDTH/DIGIT), with a minimum of 1 bit. When DIGIT=WIDTH, RUN is a single cycle.

Decomposition:
- Shared package alu_pkg holds:
  - MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - State enum IDLE/RUN/DONE.
- Sub-module addsub_slice: 1-bit combinational cell with inputs a, b, c, mode and outputs s, c'.
  - Instantiated DIGIT times and chained within a cycle.
  - Built from the existing gate primitives: xor2, and2, inv1, or2.
- FSM, counter, operand latches and flag logic live in serial_addsub.

Test Plan:
- W=8, D=1, sub, a=0x05, b=0x03, cin=0 -> result 0x02, cout=0, overflow=0, zero=0; out_valid 9 edges after accept.
- Sub 0x03-0x05 -> 0xFE, cout=1. Sub 0x80-0x01 -> 0x7F, overflow=1, cout=0. Sub 0x05-0x04 with cin=1 -> 0x00, zero=1.
- Add 0x7F+0x01 -> 0x80, overflow=1, cout=0. Add 0xFF+0x01 -> 0x00, cout=1, zero=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - result and flags stay stable; in_ready stays 0; new in_valid is ignored.
  - After out_ready, the next op is accepted one cycle later.
- Reset at cycle 3 of RUN -> next edge returns to IDLE with in_ready=1, out_valid=0, result=0. A following op completes correctly.
- W=8, D=4 and D=8: same vectors give identical results, with out_valid at 3 and 2 edges after accept respectively.
